// File: rtl/ap_avalon_driver.sv
// ap_avalon_driver: Avalon-MM sequencer feeding the Ascon permutation CSRs.
// Writes a 320-bit state as ten words, waits, reads ten words back.
module ap_avalon_driver #(
   parameter int unsigned PERM_WAIT = 10
) (
   input  logic         iClk,
   input  logic         iReset,
   input  logic         iIn_valid,
   output logic         oIn_ready,
   input  logic [319:0] iIn_state,
   output logic         oOut_valid,
   input  logic         iOut_ready,
   output logic [319:0] oOut_state,
   output logic         oChip_select_n,
   output logic         oWrite_n,
   output logic         oRead_n,
   output logic [4:0]   oAddress,
   output logic [31:0]  oWriteData,
   input  logic [31:0]  iReadData,
   output logic         oBusy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WAIT,
      S_READ,
      S_DONE
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(PERM_WAIT - 1);

   state_t        state_q, state_d;
   logic [3:0]    idx_q, idx_d;
   logic          gap_q, gap_d;
   logic [7:0]    wcnt_q, wcnt_d;
   logic [319:0]  in_q, in_d;
   logic          cs_n_q, cs_n_d;
   logic          wr_n_q, wr_n_d;
   logic          rd_n_q, rd_n_d;
   logic [4:0]    addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   res_q [10];
   logic          cap_en;

   // CSR word k: even k is the low half of x(k/2), odd k the high half.
   function automatic logic [31:0] word_of(input logic [319:0] s,
                                           input logic [3:0]   k);
      logic [31:0] w;
      w = '0;
      unique case (k)
         4'd0:    w = s[287:256];
         4'd1:    w = s[319:288];
         4'd2:    w = s[223:192];
         4'd3:    w = s[255:224];
         4'd4:    w = s[159:128];
         4'd5:    w = s[191:160];
         4'd6:    w = s[95:64];
         4'd7:    w = s[127:96];
         4'd8:    w = s[31:0];
         4'd9:    w = s[63:32];
         default: w = '0;
      endcase
      return w;
   endfunction

   // Next-state logic; bus strobes are computed one cycle ahead and registered.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      wcnt_d  = wcnt_q;
      in_d    = in_q;
      cs_n_d  = 1'b1;
      wr_n_d  = 1'b1;
      rd_n_d  = 1'b1;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (iIn_valid) begin
               in_d    = iIn_state;
               idx_d   = 4'd0;
               gap_d   = 1'b0;
               state_d = S_WRITE;
               cs_n_d  = 1'b0;
               wr_n_d  = 1'b0;
               addr_d  = 5'd1;
               wdata_d = word_of(iIn_state, 4'd0);
            end
         end
         S_WRITE: begin
            if (!gap_q) begin
               gap_d = 1'b1;
            end else if (idx_q == 4'd9) begin
               state_d = S_WAIT;
               wcnt_d  = 8'd0;
            end else begin
               idx_d   = idx_q + 4'd1;
               gap_d   = 1'b0;
               cs_n_d  = 1'b0;
               wr_n_d  = 1'b0;
               addr_d  = {1'b0, idx_q} + 5'd2;
               wdata_d = word_of(in_q, idx_q + 4'd1);
            end
         end
         S_WAIT: begin
            if (wcnt_q == WAIT_LAST) begin
               state_d = S_READ;
               idx_d   = 4'd0;
               gap_d   = 1'b0;
               wcnt_d  = 8'd0;
               cs_n_d  = 1'b0;
               rd_n_d  = 1'b0;
               addr_d  = 5'd11;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
            end
         end
         S_READ: begin
            if (!gap_q) begin
               gap_d = 1'b1;
            end else if (idx_q == 4'd9) begin
               state_d = S_DONE;
            end else begin
               idx_d  = idx_q + 4'd1;
               gap_d  = 1'b0;
               cs_n_d = 1'b0;
               rd_n_d = 1'b0;
               addr_d = {1'b0, idx_q} + 5'd12;
            end
         end
         S_DONE: begin
            if (iOut_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, sequencing counters and registered bus outputs.
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         state_q <= S_IDLE;
         idx_q   <= 4'd0;
         gap_q   <= 1'b0;
         wcnt_q  <= 8'd0;
         in_q    <= '0;
         cs_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         rd_n_q  <= 1'b1;
         addr_q  <= 5'd0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         wcnt_q  <= wcnt_d;
         in_q    <= in_d;
         cs_n_q  <= cs_n_d;
         wr_n_q  <= wr_n_d;
         rd_n_q  <= rd_n_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign cap_en = (state_q == S_READ) && !gap_q;

   // Capture read data at the edge that ends each read strobe.
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         for (int i = 0; i < 10; i++) begin
            res_q[i] <= 32'd0;
         end
      end else if (cap_en) begin
         res_q[idx_q] <= iReadData;
      end
   end

   assign oIn_ready      = (state_q == S_IDLE);
   assign oBusy          = (state_q != S_IDLE);
   assign oOut_valid     = (state_q == S_DONE);
   assign oChip_select_n = cs_n_q;
   assign oWrite_n       = wr_n_q;
   assign oRead_n        = rd_n_q;
   assign oAddress       = addr_q;
   assign oWriteData     = wdata_q;
   assign oOut_state     = {res_q[1], res_q[0], res_q[3], res_q[2],
                            res_q[5], res_q[4], res_q[7], res_q[6],
                            res_q[9], res_q[8]};

endmodule

// File: doc/ap_avalon_driver.md
# ap_avalon_driver

Avalon-MM master sequencer that sits directly upstream of the Ascon permutation CSR wrapper (`ap_wrapper`). It accepts a full 320-bit Ascon state through a valid/ready handshake. It writes the state as ten 32-bit CSR words, waits a fixed permutation interval, reads the ten result words back, and presents the permuted 320-bit state on a valid/ready output port.

## Interface
- `PERM_WAIT`, 10, idle cycles between the last write and the first read; legal range 1..255.
- `iClk`  in  1  system clock, rising edge.
- `iReset`  in  1  asynchronous, active-high reset.
- `iIn_valid`  in  1  input state valid.
- `oIn_ready`  out  1  driver can accept a state; high only in IDLE.
- `iIn_state`  in  320  input state; x0=[319:256], x1=[255:192], x2=[191:128], x3=[127:64], x4=[63:0].
- `oOut_valid`  out  1  permuted state valid; held until accepted.
- `iOut_ready`  in  1  consumer accepts the output state.
- `oOut_state`  out  320  permuted state, same packing as `iIn_state`.
- `oChip_select_n`  out  1  Avalon chip select, active low.
- `oWrite_n`  out  1  Avalon write strobe, active low.
- `oRead_n`  out  1  Avalon read strobe, active low.
- `oAddress`  out  5  CSR word address.
- `oWriteData`  out  32  CSR write data.
- `iReadData`  in  32  CSR read data from `ap_wrapper`.
- `oBusy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, WRITE, WAIT, READ, DONE.
- **IDLE**
  - `oIn_ready`=1.
  - On `iIn_valid & oIn_ready` at an edge: latch `iIn_state`, clear the word index to 0, go to WRITE.
- **WRITE**
  - Ten accesses, index k=0..9; each access is one strobe cycle followed by one gap cycle.
  - Strobe cycle: `oChip_select_n`=0, `oWrite_n`=0, `oAddress`=k+1, `oWriteData`=latched word k.
  - Word order, by address:
    - 1: x0[31:0]
    - 2: x0[63:32]
    - 3: x1[31:0]
    - 4: x1[63:32]
    - 5: x2[31:0]
    - 6: x2[63:32]
    - 7: x3[31:0]
    - 8: x3[63:32]
    - 9: x4[31:0]
    - 10: x4[63:32]
  - Gap cycle: all strobes deasserted (1).
  - After gap 9, go to WAIT.
- **WAIT**
  - Strobes deasserted; an 8-bit counter runs for exactly `PERM_WAIT` cycles.
  - Then clear the index and go to READ.
- **READ**
  - Ten accesses, same strobe/gap pattern as WRITE.
  - Strobe cycle: `oChip_select_n`=0, `oRead_n`=0, `oAddress`=k+11.
  - `iReadData` is sampled at the rising edge that ends the strobe cycle and stored into result word k; address 11+k maps to the same word slot as address 1+k.
  - After gap 9, go to DONE.
- **DONE**
  - `oOut_valid`=1 and `oOut_state` stable.
  - On `iOut_ready` at an edge: clear `oOut_valid`, go to IDLE.
- `oWrite_n` and `oRead_n` are never low in the same cycle.
- Outside strobe cycles, `oAddress` and `oWriteData` hold their last values.
- `iIn_valid` outside IDLE is ignored; no queueing.
- `oOut_state` keeps the last result until the next READ overwrites it.

## Timing
- Reset values, applied asynchronously while `iReset`=1:
  - FSM in IDLE.
  - `oIn_ready`=1, `oOut_valid`=0, `oBusy`=0.
  - `oChip_select_n`=1, `oWrite_n`=1, `oRead_n`=1.
  - `oAddress`=0, `oWriteData`=0, `oOut_state`=0.
  - Index and wait counter = 0.
- Reset mid-transaction: the current access is abandoned immediately and the strobes go high in the same cycle reset asserts. Partial results are discarded, and no output valid is ever produced for the aborted state.
- Let t0 be the acceptance edge.
  - Write strobe k occupies cycle t0+1+2k.
  - WAIT occupies cycles t0+21 .. t0+20+`PERM_WAIT`.
  - Read strobe k occupies cycle t0+21+`PERM_WAIT`+2k.
  - `oOut_valid` rises in cycle t0+41+`PERM_WAIT` (51 cycles with the default `PERM_WAIT`).
- Output acceptance: if `iOut_ready` is already high when `oOut_valid` rises, the handshake completes at that cycle's edge. `oIn_ready` is high from the next cycle.
- Back-to-back throughput: one state per 42+`PERM_WAIT` cycles.

## Test plan
- **Reset check:** hold `iReset`=1 for 3 cycles, then release.
  - Required: every output at its reset value; `oIn_ready`=1 at release.
- **Write sequence:** input state x0=0123456789ABCDEF, x1=FEDCBA9876543210, x2=1234567890ABCDEF, x3=A1B2C3D4E5F60789, x4=1111111111111111.
  - Required write sequence: addr1=89ABCDEF, addr2=01234567, …, addr9=11111111, addr10=11111111.
  - Each strobe is exactly 1 cycle, with exactly 1 gap cycle after it.
- **Read capture and output:** a CSR model returns 0xA0000000+addr on reads of addresses 11..20.
  - `oOut_state` x0 = A000000CA000000B, …, x4 = A0000014A0000013.
  - `oOut_valid` rises exactly 51 cycles after acceptance.
- **Output backpressure:** hold `iOut_ready`=0 for 7 cycles after `oOut_valid` rises.
  - Required: `oOut_valid` and `oOut_state` stay stable; `iIn_valid` is ignored; after `iOut_ready`=1, `oIn_ready`=1 on the next cycle.
- **Reset mid-operation:** assert `iReset` during the 3rd read strobe.
  - Required: strobes go high immediately; FSM returns to IDLE; `oOut_valid` never asserts.
  - A following transaction then completes correctly.
- **Short wait:** `PERM_WAIT`=1.
  - Required: exactly 1 idle cycle between write gap 9 and read strobe 0; latency is 42 cycles.
